// File: rtl/core_pkg.sv
// Shared widths, mode encodings and lane helpers for the PE-array drain path.
package core_pkg;

  localparam int LANE_W = 24;
  localparam int W18    = 16;
  localparam int IN_W   = 4 * W18;
  localparam int REV_W  = 3 * W18;

  typedef enum logic {
    MODE_88 = 1'b0,
    MODE_18 = 1'b1
  } mode_e;

  localparam logic [3:0] MASK_88 = 4'b0011;
  localparam logic [3:0] MASK_18 = 4'b1111;

  function automatic logic [LANE_W-1:0] sext(input logic [W18-1:0] v);
    return {{(LANE_W-W18){v[W18-1]}}, v};
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata reads as zero while empty.
module collector_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/core_out_collector.sv
// Row drain collector: applies packed-multiply sign correction and streams lanes to writeback.
// Optional per-lane signed saturation is enabled by defining COLLECT_SAT_EN.
module core_out_collector
  import core_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int FIFO_DEPTH = 4
`ifdef COLLECT_SAT_EN
  , parameter int SAT_W    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [REV_W-1:0]      in_revise,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*LANE_W-1:0]   out_data,
  output logic [3:0]            out_mask,
  output logic                  out_last,
  output logic                  tile_done
);

  localparam int CNT_W = $clog2(ROWS);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = 4*LANE_W + 4 + 1;

  logic [CNT_W-1:0]    beat_cnt;
  logic                accept;
  logic [CW:0]         occupancy;

  logic                s1_valid;
  logic                s1_last;
  mode_e               s1_mode;
  logic [IN_W-1:0]     s1_data;
  logic [REV_W-1:0]    s1_rev;

  logic                s2_valid;
  logic                s2_last;
  logic [3:0]          s2_mask;
  logic [4*LANE_W-1:0] s2_lanes;

  logic [4*LANE_W-1:0] lanes_raw;
  logic [4*LANE_W-1:0] lanes_c;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FW-1:0]       fifo_rdata;

  // Count beats already in the pipe so the array never has to stall mid-shift.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
  assign in_ready  = !reset && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) beat_cnt <= (beat_cnt == CNT_W'(ROWS-1)) ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= in_data;
      s1_rev  <= in_revise;
      s1_mode <= mode_e'(mode);
      s1_last <= (beat_cnt == CNT_W'(ROWS-1));
    end
    if (s1_valid) begin
      s2_lanes <= lanes_c;
      s2_mask  <= (s1_mode == MODE_18) ? MASK_18 : MASK_88;
      s2_last  <= s1_last;
    end
  end

  always_comb begin
    lanes_raw = '0;
    if (s1_mode == MODE_18) begin
      lanes_raw[0 +: LANE_W] = sext(s1_data[0 +: W18]);
      for (int k = 1; k < 4; k++)
        lanes_raw[k*LANE_W +: LANE_W] =
          sext(W18'(s1_data[k*W18 +: W18] + s1_rev[(k-1)*W18 +: W18]));
    end else begin
      lanes_raw[0 +: LANE_W]      = s1_data[0 +: LANE_W];
      lanes_raw[LANE_W +: LANE_W] = s1_data[LANE_W +: LANE_W] + s1_rev[0 +: LANE_W];
    end
  end

`ifdef COLLECT_SAT_EN
  localparam logic signed [LANE_W-1:0] SAT_HI = LANE_W'((1 << (SAT_W-1)) - 1);
  localparam logic signed [LANE_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic [LANE_W-1:0] sat(input logic [LANE_W-1:0] v);
    if ($signed(v) > SAT_HI) return SAT_HI;
    if ($signed(v) < SAT_LO) return SAT_LO;
    return v;
  endfunction

  // Unused lanes are zero, which saturation leaves untouched.
  always_comb begin
    lanes_c = '0;
    for (int k = 0; k < 4; k++)
      lanes_c[k*LANE_W +: LANE_W] = sat(lanes_raw[k*LANE_W +: LANE_W]);
  end
`else
  assign lanes_c = lanes_raw;
`endif

  collector_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s2_valid),
    .wdata ({s2_last, s2_mask, s2_lanes}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign {out_last, out_mask, out_data} = fifo_rdata;

  always_ff @(posedge clk) begin
    if (reset) tile_done <= 1'b0;
    else       tile_done <= out_valid && out_ready && out_last;
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(s2_valid && fifo_full && !out_ready));
  end

endmodule

// File: tb/tb_core_out_collector.sv
// Directed and randomized checks of core_out_collector against a lane-arithmetic reference model.
module tb_core_out_collector;

  localparam int ROWS  = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [47:0]  in_revise;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic [3:0]   out_mask;
  logic         out_last;
  logic         tile_done;

  core_out_collector #(.ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_revise (in_revise),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] data;
    logic [3:0]  mask;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          model_cnt;
  int          n_tests, n_fail;
  int          n_acc, n_pops, n_td, n_last;
  int          cyc, first_pop, last_pop_cyc;
  logic        popped, accepted;
  logic [95:0] last_pop_data;
  logic [3:0]  last_pop_mask;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to24(input int v);
    int w;
    w = v % 16777216;
    if (w < 0) w += 16777216;
    return w[23:0];
  endfunction

  function automatic int finish_lane(input int v);
    int r;
    r = v;
`ifdef COLLECT_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r;
  endfunction

  // Lane values computed as signed integers, then re-encoded as 24-bit two's complement.
  function automatic beat_t model(input logic m, input logic [63:0] d, input logic [47:0] r,
                                  input logic last);
    beat_t b;
    int a;
    b.data = '0;
    b.last = last;
    if (m) begin
      b.mask = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        a = int'(d[16*k +: 16]);
        if (k > 0) a = a + int'(r[16*(k-1) +: 16]);
        a = a % 65536;
        if (a >= 32768) a -= 65536;
        b.data[24*k +: 24] = to24(finish_lane(a));
      end
    end else begin
      b.mask = 4'b0011;
      a = int'(d[23:0]);
      if (a >= 8388608) a -= 16777216;
      b.data[23:0] = to24(finish_lane(a));
      a = (int'(d[47:24]) + int'(r[23:0])) % 16777216;
      if (a >= 8388608) a -= 16777216;
      b.data[47:24] = to24(finish_lane(a));
    end
    return b;
  endfunction

  task automatic clr();
    n_acc = 0; n_pops = 0; n_td = 0; n_last = 0; first_pop = -1; last_pop_cyc = -1;
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, check tile_done after the rise.
  task automatic step(input logic v, input logic m, input logic [63:0] d, input logic [47:0] r,
                      input logic ordy);
    logic exp_td;
    beat_t e;
    in_valid = v; mode = m; in_data = d; in_revise = r; out_ready = ordy;
    #1;
    popped = 1'b0; accepted = 1'b0; exp_td = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_mask", out_mask, e.mask);
        check("out_last", out_last, e.last);
        last_pop_data = out_data;
        last_pop_mask = out_mask;
        popped = 1'b1;
        n_pops++;
        if (out_last) n_last++;
        if (first_pop < 0) first_pop = cyc;
        last_pop_cyc = cyc;
        exp_td = e.last && !reset;
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      n_acc++;
      exp_q.push_back(model(m, d, r, model_cnt == ROWS-1));
      model_cnt = (model_cnt + 1) % ROWS;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (tile_done) n_td++;
    check("tile_done", tile_done, exp_td);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 64'd0, 48'd0, ordy);
  endtask

  task automatic rand_beat(input logic ordy);
    step(1'b1, 1'($urandom_range(1)), {$urandom(), $urandom()},
         48'({$urandom(), $urandom()}), ordy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    exp_q.delete();
    model_cnt = 0;
    reset = 1'b0;
  endtask

  int lat;
  logic found;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; model_cnt = 0;
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; in_data = '0; in_revise = '0; out_ready = 1'b0;
    clr();

    idle(1'b0);
    idle(1'b0);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_out_last", out_last, 0);
    check("rst_tile_done", tile_done, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Mode 0 directed beat and latency.
    step(1'b1, 1'b0, {16'h0000, 24'h000010, 24'hFFFFF0}, 48'd3, 1'b0);
    check("t1_accept", accepted, 1);
    lat = 0; found = 1'b0;
    for (int i = 1; i <= 8 && !found; i++) begin
      idle(1'b1);
      if (popped) begin found = 1'b1; lat = i; end
    end
    check("t1_latency", lat, 3);
    check("t1_lane0", last_pop_data[23:0], 24'hFFFFF0);
    check("t1_lane1", last_pop_data[47:24], 24'h000013);
    check("t1_mask", last_pop_mask, 4'b0011);

    // Mode 1 directed beat.
    step(1'b1, 1'b1, {16'h0001, 16'h7FFF, 16'h8000, 16'h0005}, {16'd1, 16'd2, 16'd4}, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      idle(1'b1);
      if (popped) found = 1'b1;
    end
    check("t2_popped", found, 1);
    check("t2_lane0", last_pop_data[23:0], 24'h000005);
    check("t2_lane1", last_pop_data[47:24], 24'hFF8004);
    check("t2_lane2", last_pop_data[71:48], 24'hFF8001);
    check("t2_lane3", last_pop_data[95:72], 24'h000002);
    check("t2_mask", last_pop_mask, 4'b1111);

`ifdef COLLECT_SAT_EN
    step(1'b1, 1'b0, {16'h0000, 24'h012340, 24'h000001}, 48'd5, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      idle(1'b1);
      if (popped) found = 1'b1;
    end
    check("sat_lane1", last_pop_data[47:24], 24'h007FFF);
`endif

    // Two full tiles back to back with the consumer always ready.
    do_reset();
    clr();
    for (int i = 0; i < 32; i++) rand_beat(1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("stream_acc", n_acc, 32);
    check("stream_pops", n_pops, 32);
    check("stream_no_gaps", last_pop_cyc - first_pop, 31);
    check("stream_lasts", n_last, 2);
    check("stream_tile_done", n_td, 2);

    // Back-pressure: only FIFO_DEPTH beats may enter.
    clr();
    for (int i = 0; i < 8; i++) rand_beat(1'b0);
    check("bp_accepted", n_acc, DEPTH);
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("bp_pops", n_pops, DEPTH);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset with beats in flight, then a fresh tile.
    do_reset();
    for (int i = 0; i < 3; i++) rand_beat(1'b1);
    do_reset();
    clr();
    for (int i = 0; i < 16; i++) rand_beat(1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("flush_pops", n_pops, 16);
    check("flush_lasts", n_last, 1);
    check("flush_tile_done", n_td, 1);

    // Random traffic on both sides.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0) rand_beat(1'($urandom_range(2) != 0));
      else idle(1'($urandom_range(2) != 0));
    end
    for (int i = 0; i < 12; i++) idle(1'b1);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
